alarm_buzzer_snooze: RTL
========================

# alarm_buzzer_snooze

Alarm sounder stage directly downstream of `alarm_fsm`. It latches the one-shot `alarm_sig` into a sustained, beeping buzzer output and adds snooze and dismiss handling. It also auto-silences after a time-out. It runs on the 32.768 kHz system clock and uses the 100 Hz and 1 Hz tick pulses from the clock divider. `buzzer` drives the piezo pin; `sounding` and `snoozing` feed display and LED logic.

## Interface
Parameters:
- `TONE_DIV`, default 8. Tone half-period in `clk` cycles; 32768/(2·8) = 2048 Hz.
- `BEEP_ON_TICKS`, default 25. Beep on-phase length, in `tick_100hz` pulses.
- `BEEP_OFF_TICKS`, default 25. Beep off-phase length, in `tick_100hz` pulses.
- `SNOOZE_SECONDS`, default 300. Snooze length, in `tick_1hz` pulses.
- `MAX_SOUND_SECONDS`, default 600. Auto-silence time-out, in `tick_1hz` pulses.

Ports:
- `clk`, in, 1. System clock, 32.768 kHz.
- `reset`, in, 1. Synchronous, active-high reset.
- `tick_100hz`, in, 1. One-cycle pulse at about 100 Hz.
- `tick_1hz`, in, 1. One-cycle pulse at 1 Hz.
- `alarm_sig`, in, 1. Level from `alarm_fsm`; high while ALARMING.
- `snooze_btn`, in, 1. Debounced level, active high.
- `dismiss_btn`, in, 1. Debounced level, active high.
- `buzzer`, out, 1. Gated tone output.
- `sounding`, out, 1. High in state SOUNDING.
- `snoozing`, out, 1. High in state SNOOZED.
- `snooze_left`, out, `$clog2(SNOOZE_SECONDS+1)`. Remaining snooze seconds; 0 outside SNOOZED.

## Operation
- Rising-edge detectors on `alarm_sig`, `snooze_btn` and `dismiss_btn`.
  - Each detector has one previous-value register, reset to 0.
  - Edge = current 1 AND previous 0.
  - Levels held high never re-trigger.
- States: IDLE, SOUNDING, SNOOZED. All transitions are registered.
- IDLE:
  - `alarm_sig` edge → SOUNDING.
  - Button edges are ignored.
- SOUNDING:
  - `dismiss` edge → IDLE.
  - Otherwise `snooze` edge → SNOOZED, and the snooze counter loads `SNOOZE_SECONDS`.
  - Otherwise, when the sound timer reaches `MAX_SOUND_SECONDS`, → IDLE.
- SNOOZED:
  - `dismiss` edge → IDLE.
  - Otherwise, when `tick_1hz` arrives with the snooze counter at 1 → SOUNDING.
  - Otherwise `tick_1hz` decrements the snooze counter.
  - `snooze` edges and `alarm_sig` edges are ignored.
- Every entry into SOUNDING does four things:
  - clears the sound timer;
  - clears the beep phase counter;
  - sets the beep phase to ON;
  - clears the tone divider and tone register.
- Sound timer:
  - counts `tick_1hz` pulses only while in SOUNDING;
  - is 0 at SOUNDING entry;
  - the exit test is on the registered count reaching `MAX_SOUND_SECONDS`.
- Beep pattern (SOUNDING only):
  - ON phase lasts `BEEP_ON_TICKS` `tick_100hz` pulses, then OFF phase lasts `BEEP_OFF_TICKS` pulses, repeating.
- Tone generator:
  - a divider counter runs 0..`TONE_DIV`-1;
  - the tone register toggles on wrap.
- `buzzer` = tone & beep_on & (state == SOUNDING).
- Simultaneous events:
  - dismiss has priority over snooze, time-out and snooze expiry;
  - snooze has priority over time-out in the same cycle.
- Reset:
  - state IDLE;
  - all counters 0;
  - all outputs 0;
  - edge registers 0.
- A reset during SOUNDING or SNOOZED fully abandons the alarm.
- A level-high `alarm_sig` present after reset counts as an edge on the first post-reset cycle. It therefore re-arms sounding; this is intended.

## Timing
- Latency from `alarm_sig` to `sounding`:
  - `alarm_sig` first sampled 1 at edge k means `sounding` = 1 after edge k.
  - The first `buzzer` high follows `TONE_DIV` cycles later.
- Button edge sampled at edge k means the state change is visible after edge k.
- Snooze duration: exactly `SNOOZE_SECONDS` `tick_1hz` pulses after SNOOZED entry, the state is SOUNDING after the edge of the last pulse.
- `snooze_left` is registered. It equals `SNOOZE_SECONDS` the cycle after entry and reaches 0 on the return to SOUNDING.
- Tick inputs are assumed to be single-cycle. A tick coincident with a state entry is not counted in the new state.

## Structure
- Shared package `alarm_pkg` holds:
  - the `sounder_state_t` enum (IDLE=0, SOUNDING=1, SNOOZED=2);
  - the default constants.
- One sub-module, `beep_tone_gen`, containing the tone divider and the beep phase counter.
  - Inputs: `clk`, `reset`, `clear`, `enable`, `tick_100hz`.
  - Output: gated tone.
- Top level holds the edge detectors, FSM, snooze counter and sound timer.
- Expected size: about 200 lines.

## Test plan
All scenarios use TONE_DIV=2, BEEP_ON=2, BEEP_OFF=2, SNOOZE=3, MAX=5.
- **Alarm pulse:** `alarm_sig` high for one cycle.
  - `sounding`=1 after that edge.
  - `buzzer` toggles every 2 cycles during ON, and is 0 for 2 `tick_100hz` pulses during OFF.
- **Snooze:** snooze edge while SOUNDING.
  - `snoozing`=1, `snooze_left`=3.
  - After the 3rd `tick_1hz`: `sounding`=1, `snooze_left`=0, beep restarts in ON.
- **Simultaneous buttons:** snooze and dismiss edges in the same cycle.
  - → IDLE; all outputs 0.
- **Auto-silence:** no buttons.
  - Returns to IDLE after 5 `tick_1hz` pulses.
  - A snooze edge in the cycle of the 5th tick → SNOOZED instead.
- **Held button:** `snooze_btn` held high from before the alarm.
  - No snooze occurs until it is released and pressed again.
- **Reset mid-snooze:** `reset` asserted for 1 cycle in SNOOZED with `alarm_sig` low.
  - IDLE; `snooze_left`=0; later ticks cause no sound.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm sounder stage.
package alarm_pkg;

  // Sounder FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SOUNDING = 2'd1,
    SNOOZED  = 2'd2
  } sounder_state_t;

  // Defaults for a 32.768 kHz system clock.
  localparam int DEF_TONE_DIV          = 8;    // 2048 Hz tone
  localparam int DEF_BEEP_ON_TICKS     = 25;   // 250 ms on
  localparam int DEF_BEEP_OFF_TICKS    = 25;   // 250 ms off
  localparam int DEF_SNOOZE_SECONDS    = 300;  // 5 minutes
  localparam int DEF_MAX_SOUND_SECONDS = 600;  // 10 minutes

endpackage

// File: rtl/alarm_buzzer_snooze_beep_tone_gen.sv
// Tone divider plus on/off beep phase counter; emits the gated piezo tone.
module beep_tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE_DIV       = DEF_TONE_DIV,
  parameter int BEEP_ON_TICKS  = DEF_BEEP_ON_TICKS,
  parameter int BEEP_OFF_TICKS = DEF_BEEP_OFF_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick_100hz,
  output logic tone_gated_o
);

  localparam int DW   = $clog2(TONE_DIV + 1);
  localparam int PMAX = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
  localparam int PW   = $clog2(PMAX + 1);

  logic [DW-1:0] div_q;
  logic          tone_q;
  logic [PW-1:0] ph_q;
  logic          beep_on_q;
  logic [PW-1:0] ph_last;

  // Last tick count of the current phase before it flips.
  assign ph_last = beep_on_q ? PW'(BEEP_ON_TICKS - 1) : PW'(BEEP_OFF_TICKS - 1);

  // Divider/tone and beep phase; clear restarts the pattern in the ON phase
  // with the tone low, so a tick landing on the clear cycle is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      tone_q    <= 1'b0;
      ph_q      <= '0;
      beep_on_q <= 1'b0;
    end else if (clear) begin
      div_q     <= '0;
      tone_q    <= 1'b0;
      ph_q      <= '0;
      beep_on_q <= 1'b1;
    end else if (enable) begin
      if (div_q == DW'(TONE_DIV - 1)) begin
        div_q  <= '0;
        tone_q <= ~tone_q;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (tick_100hz) begin
        if (ph_q == ph_last) begin
          ph_q      <= '0;
          beep_on_q <= ~beep_on_q;
        end else begin
          ph_q <= ph_q + 1'b1;
        end
      end
    end
  end

  assign tone_gated_o = tone_q & beep_on_q & enable;

endmodule

// File: rtl/alarm_buzzer_snooze.sv
// Alarm sounder: latches alarm_sig into a beeping buzzer with snooze,
// dismiss and auto-silence handling.
module alarm_buzzer_snooze
  import alarm_pkg::*;
#(
  parameter int TONE_DIV          = DEF_TONE_DIV,
  parameter int BEEP_ON_TICKS     = DEF_BEEP_ON_TICKS,
  parameter int BEEP_OFF_TICKS    = DEF_BEEP_OFF_TICKS,
  parameter int SNOOZE_SECONDS    = DEF_SNOOZE_SECONDS,
  parameter int MAX_SOUND_SECONDS = DEF_MAX_SOUND_SECONDS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  tick_100hz,
  input  logic                                  tick_1hz,
  input  logic                                  alarm_sig,
  input  logic                                  snooze_btn,
  input  logic                                  dismiss_btn,
  output logic                                  buzzer,
  output logic                                  sounding,
  output logic                                  snoozing,
  output logic [$clog2(SNOOZE_SECONDS+1)-1:0]   snooze_left
);

  localparam int SW = $clog2(SNOOZE_SECONDS + 1);
  localparam int TW = $clog2(MAX_SOUND_SECONDS + 1);

  sounder_state_t state_q, state_d;
  logic [SW-1:0]  snz_q, snz_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           alarm_prev_q, snz_prev_q, dis_prev_q;
  logic           sounding_q, snoozing_q;
  logic           alarm_rise, snz_rise, dis_rise;
  logic           enter_snd;

  assign alarm_rise = alarm_sig   & ~alarm_prev_q;
  assign snz_rise   = snooze_btn  & ~snz_prev_q;
  assign dis_rise   = dismiss_btn & ~dis_prev_q;

  // Next state and counters. Dismiss beats everything; snooze beats the
  // time-out. enter_snd flags any transition into SOUNDING.
  always_comb begin
    state_d   = state_q;
    snz_d     = snz_q;
    tmr_d     = tmr_q;
    enter_snd = 1'b0;
    case (state_q)
      IDLE: begin
        if (alarm_rise) begin
          state_d   = SOUNDING;
          tmr_d     = '0;
          enter_snd = 1'b1;
        end
      end
      SOUNDING: begin
        if (dis_rise) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (snz_rise) begin
          state_d = SNOOZED;
          snz_d   = SW'(SNOOZE_SECONDS);
          tmr_d   = '0;
        end else if (tmr_q == TW'(MAX_SOUND_SECONDS)) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tick_1hz) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SNOOZED: begin
        if (dis_rise) begin
          state_d = IDLE;
          snz_d   = '0;
        end else if (tick_1hz) begin
          if (snz_q == SW'(1)) begin
            state_d   = SOUNDING;
            snz_d     = '0;
            tmr_d     = '0;
            enter_snd = 1'b1;
          end else if (snz_q != '0) begin
            snz_d = snz_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        snz_d   = '0;
        tmr_d   = '0;
      end
    endcase
  end

  // State, counters, edge history and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      snz_q        <= '0;
      tmr_q        <= '0;
      alarm_prev_q <= 1'b0;
      snz_prev_q   <= 1'b0;
      dis_prev_q   <= 1'b0;
      sounding_q   <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      snz_q        <= snz_d;
      tmr_q        <= tmr_d;
      alarm_prev_q <= alarm_sig;
      snz_prev_q   <= snooze_btn;
      dis_prev_q   <= dismiss_btn;
      sounding_q   <= (state_d == SOUNDING);
      snoozing_q   <= (state_d == SNOOZED);
    end
  end

  beep_tone_gen #(
    .TONE_DIV       (TONE_DIV),
    .BEEP_ON_TICKS  (BEEP_ON_TICKS),
    .BEEP_OFF_TICKS (BEEP_OFF_TICKS)
  ) u_beep (
    .clk          (clk),
    .reset        (reset),
    .clear        (enter_snd),
    .enable       (sounding_q),
    .tick_100hz   (tick_100hz),
    .tone_gated_o (buzzer)
  );

  assign sounding    = sounding_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snz_q;

endmodule
